// File: rtl/input_arb_rr_pkg.sv
// Shared types and constants for the AXI read arbiters.
package input_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         AXI_AW    = 40;

endpackage

// File: rtl/input_arb_rr_pick.sv
// Round-robin priority encoder: first set request after 'last', wrapping.
module rr_pick #(
    parameter  int NP = 4,
    localparam int LW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic [NP-1:0] req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] idx,
    output logic          any
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NP; k >= 1; k--) begin
            j = (int'(last) + k) % NP;
            if (req[j]) begin
                idx = LW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_arb_rr.sv
// Round-robin arbiter sharing one AXI read master among NP burst requesters.
module input_arb_rr
    import input_arb_pkg::*;
#(
    parameter int NP   = 4,
    parameter int DW   = 64,
    parameter int AW   = 24,
    parameter int NTFR = 64
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic [NP-1:0]         rreq,
    input  logic [AW-1:0]         radr [NP],
    output logic [NP-1:0]         rack,
    output logic [DW-1:0]         rdata [NP],
    output logic [NP-1:0]         rdone,
    input  logic [31:0]           baseadr,
    output logic [AXI_AW-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DW-1:0]         rd_data,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready,
    output logic                  busy,
    output logic                  err
);

    localparam int BB = $clog2(NTFR * DW / 8);
    localparam int LW = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW = $clog2(NTFR);
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-BB){1'b1}}, {BB{1'b0}}};

    state_t         state_reg;
    logic [LW-1:0]  ch_reg;
    logic [LW-1:0]  last_reg;
    logic [CW-1:0]  cnt_reg;
    logic [AW-1:0]  adr_reg;
    logic           arvalid_reg;
    logic           rready_reg;
    logic           err_reg;
    logic [NP-1:0]  rdone_reg;

    logic [LW-1:0]  pick_idx;
    logic           pick_any;
    logic           beat;
    logic           final_beat;
    logic           beat_bad;

    rr_pick #(.NP(NP)) u_pick (
        .req  (rreq),
        .last (last_reg),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign beat       = rready_reg && rvalid;
    assign final_beat = (cnt_reg == CW'(NTFR - 1));
    // rlast must coincide exactly with the NTFR-th beat.
    assign beat_bad   = (rresp != RESP_OKAY) || (rlast != final_beat);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= ST_IDLE;
            ch_reg      <= '0;
            last_reg    <= LW'(NP - 1);
            cnt_reg     <= '0;
            adr_reg     <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            err_reg     <= 1'b0;
            rdone_reg   <= '0;
        end else begin
            rdone_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_reg   <= ST_ADDR;
                        ch_reg      <= pick_idx;
                        adr_reg     <= radr[pick_idx];
                        arvalid_reg <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        state_reg   <= ST_DATA;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        last_reg    <= ch_reg;
                        cnt_reg     <= '0;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (beat_bad)
                            err_reg <= 1'b1;
                        if (final_beat) begin
                            rready_reg        <= 1'b0;
                            rdone_reg[ch_reg] <= 1'b1;
                            state_reg         <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign araddr  = AXI_AW'(adr_reg & ALIGN_MASK) + AXI_AW'(baseadr);
    assign arlen   = 8'(NTFR - 1);
    assign arvalid = arvalid_reg;
    assign rready  = rready_reg;
    assign rdone   = rdone_reg;
    assign err     = err_reg;
    assign busy    = (state_reg != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_ch
            assign rack[gi]  = (state_reg == ST_DATA) && (ch_reg == LW'(gi)) && rvalid;
            assign rdata[gi] = rack[gi] ? rd_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_input_arb_rr.sv
// Randomised scoreboard bench for input_arb_rr against a burst-level reference model.
module tb_input_arb_rr;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int AW   = 24;
    localparam int NTFR = 4;
    localparam int BB   = $clog2(NTFR * DW / 8);

    logic          aclk;
    logic          arst_n;
    logic [NP-1:0] rreq;
    logic [AW-1:0] radr [NP];
    logic [NP-1:0] rack;
    logic [DW-1:0] rdata [NP];
    logic [NP-1:0] rdone;
    logic [31:0]   baseadr;
    logic [39:0]   araddr;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rd_data;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rlast;
    logic          rready;
    logic          busy;
    logic          err;

    input_arb_rr #(.NP(NP), .DW(DW), .AW(AW), .NTFR(NTFR)) dut (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .rreq    (rreq),
        .radr    (radr),
        .rack    (rack),
        .rdata   (rdata),
        .rdone   (rdone),
        .baseadr (baseadr),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rd_data (rd_data),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rready  (rready),
        .busy    (busy),
        .err     (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic          arvalid;
        logic [39:0]   araddr;
        logic          rready;
        logic          busy;
        logic          err;
        logic [NP-1:0] rack;
        logic [NP-1:0] rdone;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = address phase, 2 = data phase
    int          m_state;
    int          m_ch;
    int          m_last;
    int          m_cnt;
    bit          m_err;
    bit          m_rdone;
    int          m_rdone_ch;
    logic [39:0] m_addr;
    bit [NP-1:0] pending;
    logic [AW-1:0] radr_v [NP];

    // Stimulus knobs
    int          p_req;
    bit [NP-1:0] allow;
    int          ar_wait;
    int          ar_wait_cnt;
    int          rv_mode;
    int          rv_phase;
    bit          rst_act;
    bit          inj_err;
    logic [39:0] seen_araddr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic cycle();
        exp_t          e;
        int            j;
        logic [AW-1:0] al;
        @(negedge aclk);
        arst_n = !rst_act;
        if (rst_act) begin
            m_state = 0; m_ch = 0; m_last = NP - 1; m_cnt = 0;
            m_err = 1'b0; m_rdone = 1'b0; pending = '0;
        end
        for (int i = 0; i < NP; i++) begin
            if (!pending[i] && allow[i] && ($urandom_range(99) < p_req)) begin
                pending[i] = 1'b1;
                radr_v[i]  = AW'($urandom);
            end
        end
        rreq = pending;
        for (int i = 0; i < NP; i++) radr[i] = radr_v[i];

        if (m_state == 1) begin
            if (ar_wait_cnt > 0) begin
                arready = 1'b0;
                ar_wait_cnt--;
            end else begin
                arready = 1'b1;
            end
        end else begin
            arready = 1'($urandom_range(1));
        end

        rd_data = {$urandom, $urandom};
        if (m_state == 2) begin
            case (rv_mode)
                0:       rvalid = 1'b1;
                1:       rvalid = 1'($urandom_range(1));
                default: begin rvalid = (rv_phase % 3 == 0); rv_phase++; end
            endcase
            rresp = 2'b00;
            rlast = (m_cnt == NTFR - 1);
            if (inj_err) begin
                if (m_cnt == 1) rresp = 2'b10;
                if (m_cnt == 2) rlast = 1'b1;
            end
        end else begin
            // junk on the R channel outside the data phase must be ignored
            rvalid = 1'($urandom_range(1));
            rresp  = 2'($urandom_range(3));
            rlast  = 1'($urandom_range(1));
        end
        #1;

        e.arvalid = (m_state == 1);
        e.araddr  = m_addr;
        e.rready  = (m_state == 2);
        e.busy    = (m_state != 0);
        e.err     = m_err;
        e.rack    = '0;
        if (m_state == 2 && rvalid) e.rack[m_ch] = 1'b1;
        e.rdone   = '0;
        if (m_rdone) e.rdone[m_rdone_ch] = 1'b1;
        e.data    = rd_data;
        exp_q.push_back(e);

        if (!rst_act) begin
            m_rdone = 1'b0;
            case (m_state)
                0: if (pending != '0) begin
                    for (int k = 1; k <= NP; k++) begin
                        j = (m_last + k) % NP;
                        if (pending[j]) begin
                            m_ch = j;
                            break;
                        end
                    end
                    al          = (radr_v[m_ch] >> BB) << BB;
                    m_addr      = 40'(al) + 40'(baseadr);
                    ar_wait_cnt = (ar_wait < 0) ? int'($urandom_range(3)) : ar_wait;
                    m_state     = 1;
                end
                1: if (arready) begin
                    m_state  = 2;
                    m_last   = m_ch;
                    m_cnt    = 0;
                    rv_phase = 0;
                end
                default: if (rvalid) begin
                    if (rresp != 2'b00 || rlast != (m_cnt == NTFR - 1)) m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == NTFR) begin
                        m_state     = 0;
                        m_rdone     = 1'b1;
                        m_rdone_ch  = m_ch;
                        pending[m_ch] = 1'b0;
                        inj_err     = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic drain(input string nm, input int maxc);
        int n;
        n = 0;
        while ((pending != '0 || m_state != 0 || m_rdone) && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=<%0d", nm, n, maxc);
        end
        cycle();
    endtask

    // Monitor: pops one expectation per cycle and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("arvalid", 64'(arvalid), 64'(e.arvalid));
                chk("rready",  64'(rready),  64'(e.rready));
                chk("busy",    64'(busy),    64'(e.busy));
                chk("err",     64'(err),     64'(e.err));
                chk("rack",    64'(rack),    64'(e.rack));
                chk("rdone",   64'(rdone),   64'(e.rdone));
                chk("arlen",   64'(arlen),   64'(NTFR - 1));
                if (e.arvalid) chk("araddr", 64'(araddr), 64'(e.araddr));
                for (int i = 0; i < NP; i++)
                    chk($sformatf("rdata%0d", i), rdata[i], e.rack[i] ? e.data : 64'd0);
                if (arvalid && arready) seen_araddr = araddr;
            end
        end
    end

    initial begin
        int n;
        arst_n = 1'b0; rst_act = 1'b1; p_req = 0; allow = '0; ar_wait = 0;
        rv_mode = 0; rv_phase = 0; inj_err = 1'b0; ar_wait_cnt = 0;
        baseadr = 32'h8000_0000; rreq = '0; arready = 1'b0; rvalid = 1'b0;
        rd_data = '0; rresp = 2'b00; rlast = 1'b0; seen_araddr = '0;
        m_state = 0; m_ch = 0; m_last = NP - 1; m_cnt = 0; m_err = 1'b0;
        m_rdone = 1'b0; m_rdone_ch = 0; m_addr = '0; pending = '0;
        for (int i = 0; i < NP; i++) begin radr_v[i] = '0; radr[i] = '0; end

        repeat (3) cycle();
        rst_act = 1'b0;

        // single burst on channel 2 at a known address
        pending[2] = 1'b1; radr_v[2] = 24'h001234;
        drain("single", 100);
        chk("single_araddr", 64'(seen_araddr), 64'h00_8000_1220);

        // all channels requesting continuously
        allow = '1; p_req = 100;
        repeat (60) cycle();
        p_req = 0;
        drain("allreq", 200);

        // slow arready
        ar_wait = 10; pending[1] = 1'b1; radr_v[1] = AW'($urandom);
        drain("arwait", 100);

        // gapped rvalid 1 on 2 off
        ar_wait = 0; rv_mode = 2; pending[3] = 1'b1; radr_v[3] = AW'($urandom);
        drain("gapped", 100);

        // bad response then early rlast
        rv_mode = 0; inj_err = 1'b1; pending[0] = 1'b1; radr_v[0] = AW'($urandom);
        drain("errburst", 100);

        // random traffic
        p_req = 30; ar_wait = -1; rv_mode = 1;
        repeat (400) cycle();
        p_req = 0;
        drain("random", 300);

        // reset during the data phase after two beats
        ar_wait = 0; rv_mode = 0; pending[1] = 1'b1; radr_v[1] = AW'($urandom);
        n = 0;
        while (!(m_state == 2 && m_cnt == 2) && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL reach_beat2_timeout actual=%0d cycles required=<50", n);
        end
        rst_act = 1'b1;
        repeat (3) cycle();
        rst_act = 1'b0;
        p_req = 100;
        repeat (30) cycle();
        p_req = 0;
        drain("postreset", 200);

        repeat (2) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
